// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: direction/target, link write, held PC
// redirect to fetch across the delay slot, and taken/not-taken statistics.
module branch_resolve_unit #(
  parameter int          CNT_W    = 32,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       br_op,
  input  logic [3:0]       cmp_flags,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [31:0]      pc,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [4:0]       rd,
  input  logic             ds_valid,
  input  logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             link_we,
  output logic [4:0]       link_waddr,
  output logic [31:0]      link_wdata,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_BEQ = 4'd1, OP_BNE = 4'd2, OP_BGEZ = 4'd3,
    OP_BGTZ = 4'd4, OP_BLEZ = 4'd5, OP_BLTZ = 4'd6, OP_BGEZAL = 4'd7,
    OP_BLTZAL = 4'd8, OP_J = 4'd9, OP_JAL = 4'd10, OP_JR = 4'd11,
    OP_JALR = 4'd12
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DS, S_REDIRECT} state_t;

  typedef struct packed {
    logic        op_ok;
    logic        is_cond;
    logic        taken;
    logic        link;
    logic [4:0]  link_addr;
    logic [31:0] target;
  } dec_t;

  state_t            r_state, w_next;
  dec_t              w_dec;
  logic              w_ge0, w_gt0, w_le0, w_lt0;
  logic [31:0]       w_pc4, w_pc8, w_br_tgt;
  logic              w_accept;

  logic              r_redirect_valid;
  logic [31:0]       r_redirect_pc;
  logic              r_link_we;
  logic [4:0]        r_link_waddr;
  logic [31:0]       r_link_wdata;
  logic [CNT_W-1:0]  r_taken_cnt, r_nottaken_cnt;

  assign {w_ge0, w_gt0, w_le0, w_lt0} = cmp_flags;
  assign w_pc4    = pc + 32'd4;
  assign w_pc8    = pc + 32'd8;
  assign w_br_tgt = w_pc4 + {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    w_dec           = '0;
    w_dec.link_addr = LINK_REG;
    w_dec.target    = w_br_tgt;
    case (br_op)
      OP_BEQ:    begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = (rs_val == rt_val); end
      OP_BNE:    begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = (rs_val != rt_val); end
      OP_BGEZ:   begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = w_ge0; end
      OP_BGTZ:   begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = w_gt0; end
      OP_BLEZ:   begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = w_le0; end
      OP_BLTZ:   begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = w_lt0; end
      OP_BGEZAL: begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = w_ge0; w_dec.link = 1'b1; end
      OP_BLTZAL: begin w_dec.op_ok = 1'b1; w_dec.is_cond = 1'b1; w_dec.taken = w_lt0; w_dec.link = 1'b1; end
      OP_J: begin
        w_dec.op_ok  = 1'b1;
        w_dec.taken  = 1'b1;
        w_dec.target = {w_pc4[31:28], instr_index, 2'b00};
      end
      OP_JAL: begin
        w_dec.op_ok  = 1'b1;
        w_dec.taken  = 1'b1;
        w_dec.link   = 1'b1;
        w_dec.target = {w_pc4[31:28], instr_index, 2'b00};
      end
      OP_JR: begin
        w_dec.op_ok  = 1'b1;
        w_dec.taken  = 1'b1;
        w_dec.target = rs_val;
      end
      OP_JALR: begin
        // rd==0 would write r0, so the link write is dropped entirely
        w_dec.op_ok     = 1'b1;
        w_dec.taken     = 1'b1;
        w_dec.link      = (rd != 5'd0);
        w_dec.link_addr = rd;
        w_dec.target    = rs_val;
      end
      default: ;
    endcase
  end

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready & ~flush & w_dec.op_ok;

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_accept && w_dec.taken) w_next = ds_valid ? S_REDIRECT : S_WAIT_DS;
        S_WAIT_DS:  if (ds_valid) w_next = S_REDIRECT;
        S_REDIRECT: if (r_redirect_valid && redirect_ready) w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_next;
      r_redirect_valid <= (w_next == S_REDIRECT);
      if (w_accept && w_dec.taken) r_redirect_pc <= w_dec.target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_link_we    <= 1'b0;
      r_link_waddr <= '0;
      r_link_wdata <= '0;
    end else begin
      r_link_we <= w_accept & w_dec.link;
      if (w_accept && w_dec.link) begin
        r_link_waddr <= w_dec.link_addr;
        r_link_wdata <= w_pc8;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_taken_cnt    <= '0;
      r_nottaken_cnt <= '0;
    end else if (w_accept && w_dec.is_cond) begin
      if (w_dec.taken) r_taken_cnt    <= r_taken_cnt + CNT_W'(1);
      else             r_nottaken_cnt <= r_nottaken_cnt + CNT_W'(1);
    end
  end

  // a flush landing on the strobe cycle kills the already-scheduled link write
  assign link_we        = r_link_we & ~flush;
  assign link_waddr     = r_link_waddr;
  assign link_wdata     = r_link_wdata;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign taken_cnt      = r_taken_cnt;
  assign nottaken_cnt   = r_nottaken_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed check of branch_resolve_unit against a behavioural
// pending-redirect model.
module tb_branch_resolve_unit;
  localparam int CW = 4;

  logic clk = 1'b0, resetn = 1'b0;
  logic in_valid, in_ready;
  logic [3:0] br_op, cmp_flags;
  logic [31:0] rs_val, rt_val, pc;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [4:0] rd;
  logic ds_valid, flush, redirect_valid, redirect_ready, link_we;
  logic [31:0] redirect_pc, link_wdata;
  logic [4:0] link_waddr;
  logic [CW-1:0] taken_cnt, nottaken_cnt;

  int total = 0, bad = 0;

  branch_resolve_unit #(.CNT_W(CW), .LINK_REG(5'd31)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .br_op(br_op), .cmp_flags(cmp_flags), .rs_val(rs_val), .rt_val(rt_val),
    .pc(pc), .imm16(imm16), .instr_index(instr_index), .rd(rd),
    .ds_valid(ds_valid), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .link_we(link_we), .link_waddr(link_waddr), .link_wdata(link_wdata),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  always #5 clk = ~clk;

  // model: a pending redirect (target) which becomes visible once the delay slot is seen
  bit        m_busy, m_ds, m_link;
  bit [31:0] m_tgt, m_ldata;
  bit [4:0]  m_laddr;
  int        m_taken, m_nt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ds = 0; m_link = 0; m_tgt = 0; m_ldata = 0; m_laddr = 0;
    m_taken = 0; m_nt = 0;
  endtask

  function automatic bit [3:0] flags_of(input logic [31:0] v);
    int s = $signed(v);
    return {s >= 0, s > 0, s <= 0, s < 0};
  endfunction

  task automatic check_outs();
    chk("in_ready", in_ready, !m_busy);
    chk("redirect_valid", redirect_valid, m_busy && m_ds);
    if (m_busy && m_ds) chk("redirect_pc", redirect_pc, m_tgt);
    chk("link_we", link_we, m_link && !flush);
    if (m_link && !flush) begin
      chk("link_waddr", link_waddr, m_laddr);
      chk("link_wdata", link_wdata, m_ldata);
    end
    chk("taken_cnt", taken_cnt, m_taken % 16);
    chk("nottaken_cnt", nottaken_cnt, m_nt % 16);
  endtask

  task automatic model_update();
    bit acc, tk, lnk;
    bit [31:0] tgt;
    int op = br_op;
    acc = 0; tk = 0; lnk = 0; tgt = 0;
    if (flush) begin
      m_busy = 0; m_ds = 0; m_link = 0;
      return;
    end
    acc = in_valid && !m_busy && op >= 1 && op <= 12;
    if (m_busy) begin
      if (!m_ds) m_ds = ds_valid;
      else if (redirect_ready) m_busy = 0;
    end
    m_link = 0;
    if (acc) begin
      case (op)
        1: tk = rs_val == rt_val;
        2: tk = rs_val != rt_val;
        3, 7: tk = cmp_flags[3];
        4: tk = cmp_flags[2];
        5: tk = cmp_flags[1];
        6, 8: tk = cmp_flags[0];
        default: tk = 1;
      endcase
      if (op <= 8) tgt = pc + 4 + 32'($signed(imm16) * 4);
      else if (op <= 10) tgt = ((pc + 4) & 32'hF000_0000) | (32'(instr_index) * 4);
      else tgt = rs_val;
      if (op <= 8) begin
        if (tk) m_taken++; else m_nt++;
      end
      lnk = (op == 7 || op == 8 || op == 10 || (op == 12 && rd != 0));
      if (lnk) begin
        m_link = 1; m_laddr = (op == 12) ? rd : 5'd31; m_ldata = pc + 8;
      end
      if (tk) begin
        m_busy = 1; m_ds = ds_valid; m_tgt = tgt;
      end
    end
  endtask

  task automatic step(input bit v, input int op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] p, input logic [15:0] imm, input bit ds,
                      input bit fl, input bit rdy);
    @(negedge clk);
    in_valid = v; br_op = 4'(op); rs_val = rs; rt_val = rt; cmp_flags = flags_of(rs);
    pc = p; imm16 = imm; instr_index = 26'($urandom); rd = 5'($urandom);
    ds_valid = ds; flush = fl; redirect_ready = rdy;
    #1;
    check_outs();
    model_update();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_link_we", link_we, 0);
    chk("rst_link_waddr", link_waddr, 0);
    chk("rst_link_wdata", link_wdata, 0);
    chk("rst_taken", taken_cnt, 0);
    chk("rst_nottaken", nottaken_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    in_valid = 0; br_op = 0; cmp_flags = 0; rs_val = 0; rt_val = 0; pc = 0;
    imm16 = 0; instr_index = 0; rd = 0; ds_valid = 0; flush = 0; redirect_ready = 0;
    model_reset();
    do_reset();

    // BGEZ rs=0 taken with delay slot in the same cycle
    step(1, 3, 0, 1, 32'h0040_0000, 16'h0004, 1, 0, 0);
    @(posedge clk); #1;
    chk("bgez_redirect_valid", redirect_valid, 1);
    chk("bgez_redirect_pc", redirect_pc, 32'h0040_0014);
    chk("bgez_taken", taken_cnt, 1);
    idle(1, 1);
    // BLTZ rs=5: not taken
    step(1, 6, 32'd5, 0, 32'h0040_0040, 16'h0010, 0, 0, 0);
    idle(1, 0);
    // BLTZAL not taken: link pulse only
    step(1, 8, 32'd5, 0, 32'h0040_0100, 16'h0008, 0, 0, 0);
    idle(2, 0);
    // JR with ds three cycles later, fetch stalls two cycles
    step(1, 11, 32'h8000_1000, 0, 32'h0040_0200, 0, 0, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2, 0);
    idle(1, 1);
    idle(1, 0);
    // taken BNE, flush while waiting for the delay slot
    step(1, 2, 32'd1, 32'd2, 32'h0040_0300, 16'hFFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2, 1);
    // taken BNE, flush in REDIRECT alongside redirect_ready
    step(1, 2, 32'd1, 32'd2, 32'h0040_0400, 16'h0002, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2, 1);

    // async reset during REDIRECT
    step(1, 9, 0, 0, 32'h1040_0000, 0, 1, 0, 0);
    idle(1, 0);
    do_reset();

    // 16 taken conditional branches wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 32'd7, 32'd7, 32'h0000_1000, 16'(i), 1, 0, 1);
      idle(1, 1);
    end
    chk("wrap_taken", taken_cnt, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs, rt;
      int sel = $urandom_range(0, 3);
      rs = (sel == 0) ? 32'd0 : $urandom;
      rt = (sel == 1) ? rs : $urandom;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 15), rs, rt, $urandom, 16'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 19) == 0, $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
